// File: rtl/demux_nof1_pkg.sv
// Shared defaults and a lane-offset helper for the 1-to-N packet demultiplexer.
package demux_nof1_pkg;

  localparam int unsigned DEF_NUM_PORTS_WIDTH = 32'd2;
  localparam int unsigned DEF_DATA_WIDTH      = 32'd32;

  // Bit offset of a port's lane inside the flattened out_data bus.
  function automatic int unsigned lane_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/demux_nof1_port_slot.sv
// One-entry valid/ready register slot holding {last, data} for a single output port.
// A load always wins over a drain, so a beat arriving while the held beat leaves
// keeps the slot full with no bubble.
module demux_port_slot #(
  parameter int unsigned DATA_WIDTH = 32'd32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  load_last_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                valid_q, valid_d;
  logic [DATA_WIDTH:0] payload_q, payload_d;

  // Next-state: load has priority, otherwise a completed handshake empties the slot.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load_i) begin
      valid_d   = 1'b1;
      payload_d = {load_last_i, load_data_i};
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot storage; the payload only changes on a load, so it is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = payload_q[DATA_WIDTH];
  assign data_o  = payload_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/demux_nof1.sv
// Registered 1-to-N packet demultiplexer. The destination is captured on the first
// beat of a packet and held until the beat carrying in_last; each output port owns
// a one-entry slot so a stalled consumer never disturbs the other ports.
module demux_nof1
  import demux_nof1_pkg::*;
#(
  parameter int unsigned NUM_PORTS_WIDTH = DEF_NUM_PORTS_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_PORTS_WIDTH-1:0]                select,
  input  logic                                      in_valid,
  input  logic                                      in_last,
  input  logic [DATA_WIDTH-1:0]                     in_data,
  output logic                                      in_ready,
  output logic [(32'd2**NUM_PORTS_WIDTH)-1:0]            out_valid,
  output logic [(32'd2**NUM_PORTS_WIDTH)-1:0]            out_last,
  output logic [(32'd2**NUM_PORTS_WIDTH)*DATA_WIDTH-1:0] out_data,
  input  logic [(32'd2**NUM_PORTS_WIDTH)-1:0]            out_ready,
  output logic                                      busy
);

  localparam int unsigned NUM_PORTS = 32'd2 ** NUM_PORTS_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [NUM_PORTS_WIDTH-1:0] dest_q, dest_d;
  logic [NUM_PORTS_WIDTH-1:0] eff_s;
  logic                       in_ready_s;
  logic                       accept_s;
  logic [NUM_PORTS-1:0]       load_s;
  logic [NUM_PORTS-1:0]       slot_valid_s;
  logic [NUM_PORTS-1:0]       slot_last_s;

  // Effective port: live select on a packet's first beat, latched destination afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_s = select;
    end else begin
      eff_s = dest_q;
    end
  end

  // Ready depends only on the target slot, never on in_valid.
  assign in_ready_s = !slot_valid_s[eff_s] || out_ready[eff_s];
  assign accept_s   = in_valid && in_ready_s;
  assign in_ready   = in_ready_s;

  // Steer the accepted beat into exactly one port slot.
  always_comb begin
    load_s = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      load_s[p] = accept_s && (eff_s == NUM_PORTS_WIDTH'(p));
    end
  end

  // Packet framing: enter BURST after a non-last first beat, leave on the last beat.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          dest_d = select;
          if (in_last) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (accept_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dest_d  = '0;
      end
    endcase
  end

  // FSM state and latched destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  assign busy = (state_q == ST_BURST);

  // One register slot per output port.
  for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_slot
    localparam int unsigned LSB = lane_lsb(p, DATA_WIDTH);

    demux_port_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load_s[p]),
      .load_last_i (in_last),
      .load_data_i (in_data),
      .ready_i     (out_ready[p]),
      .valid_o     (slot_valid_s[p]),
      .last_o      (slot_last_s[p]),
      .data_o      (out_data[LSB +: DATA_WIDTH])
    );
  end

  assign out_valid = slot_valid_s;
  assign out_last  = slot_last_s;

endmodule

// File: tb/tb_demux_nof1.sv
// Self-checking bench for demux_nof1: directed scenarios plus randomized traffic,
// with per-port expected-beat queues filled on input acceptance and drained by a monitor.
module tb_demux_nof1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   select;
  logic         in_valid;
  logic         in_last;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   out_last;
  logic [127:0] out_data;
  logic [3:0]   out_ready;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [32:0] exp_q [4][$];
  bit          in_pkt = 1'b0;
  logic [1:0]  cur_dest = 2'd0;
  logic [1:0]  port_m;
  bit          port1_seen = 1'b0;
  bit          stalled_prev [4];
  logic [32:0] prev_beat [4];
  logic [32:0] beat_m;
  logic [32:0] head_m;

  demux_nof1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int p);
    return out_data[p*32 +: 32];
  endfunction

  // Input-side observer: every accepted beat is routed by packet rules into a port queue.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_pkt   = 1'b0;
      cur_dest = 2'd0;
      for (int p = 0; p < 4; p++) exp_q[p].delete();
    end else if (in_valid && in_ready) begin
      port_m = in_pkt ? cur_dest : select;
      if (!in_pkt) cur_dest = select;
      in_pkt = !in_last;
      exp_q[port_m].push_back({in_last, in_data});
    end
  end

  // Output-side monitor: pops on each output handshake and checks stall stability.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) stalled_prev[p] = 1'b0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        beat_m = {out_last[p], lane(p)};
        if (stalled_prev[p])
          check($sformatf("stable_p%0d", p), {out_valid[p], beat_m}, {1'b1, prev_beat[p]});
        if (p == 1 && out_valid[p]) port1_seen = 1'b1;
        if (out_valid[p] && out_ready[p]) begin
          if (exp_q[p].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat_p%0d: got 0x%0h expected no beat", p, beat_m);
          end else begin
            head_m = exp_q[p].pop_front();
            check($sformatf("beat_p%0d", p), beat_m, head_m);
          end
        end
        stalled_prev[p] = out_valid[p] && !out_ready[p];
        prev_beat[p]    = beat_m;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Present one beat and hold it until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic last, input logic [31:0] d, input bit chk);
    int t = 0;
    in_valid = 1'b1;
    select   = sel;
    in_last  = last;
    in_data  = d;
    @(negedge clk);
    if (chk) check("in_ready_now", {63'd0, in_ready}, 64'd1);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int remaining = 0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    select    = 2'd0;
    in_data   = 32'd0;
    out_ready = 4'hF;

    // reset state
    #1;
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    check("rst_out_last", {60'd0, out_last}, 64'd0);
    check("rst_out_data_or", {63'd0, |out_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    #21 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // 1-beat packets to each port back-to-back
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 1'b1, 32'hA0 + 32'(i), 1'b1);
      check($sformatf("lat_valid_%0d", i), {60'd0, out_valid}, 64'(4'b0001 << i));
      check($sformatf("lat_data_%0d", i), {32'd0, lane(i)}, 64'(32'hA0 + 32'(i)));
    end

    // 4-beat packet: destination held while select wanders
    port1_seen = 1'b0;
    send(2'd2, 1'b0, 32'hB0, 1'b0);
    check("burst_busy_1", {63'd0, busy}, 64'd1);
    send(2'd1, 1'b0, 32'hB1, 1'b0);
    check("burst_busy_2", {63'd0, busy}, 64'd1);
    send(2'd1, 1'b0, 32'hB2, 1'b0);
    check("burst_busy_3", {63'd0, busy}, 64'd1);
    send(2'd1, 1'b1, 32'hB3, 1'b0);
    check("burst_busy_end", {63'd0, busy}, 64'd0);
    check("burst_last_p2", {63'd0, out_last[2]}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("burst_port1_quiet", {63'd0, port1_seen}, 64'd0);

    // backpressure on port 3
    out_ready = 4'b0111;
    send(2'd3, 1'b0, 32'hC0, 1'b1);
    check("bp_busy", {63'd0, busy}, 64'd1);
    in_valid = 1'b1;
    select   = 2'd0;
    in_last  = 1'b1;
    in_data  = 32'hC1;
    @(negedge clk);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    repeat (2) @(negedge clk);
    check("bp_in_ready_still_low", {63'd0, in_ready}, 64'd0);
    check("bp_hold_data", {32'd0, lane(3)}, 64'hC0);
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 4'b0111;
    check("bp_reload_valid", {63'd0, out_valid[3]}, 64'd1);
    check("bp_reload_data", {32'd0, lane(3)}, 64'hC1);
    check("bp_burst_done", {63'd0, busy}, 64'd0);
    send(2'd0, 1'b1, 32'hC2, 1'b1);
    check("bp_p0_loaded", {63'd0, out_valid[0]}, 64'd1);
    check("bp_p3_still_held", {63'd0, out_valid[3]}, 64'd1);
    out_ready = 4'hF;

    // drain and load on the same port in the same cycle
    out_ready = 4'b1101;
    send(2'd1, 1'b1, 32'hD0, 1'b1);
    out_ready = 4'hF;
    send(2'd1, 1'b1, 32'h55, 1'b1);
    check("dl_valid", {63'd0, out_valid[1]}, 64'd1);
    check("dl_data", {32'd0, lane(1)}, 64'h55);

    // asynchronous reset in the middle of a packet
    out_ready = 4'b1011;
    send(2'd2, 1'b0, 32'hE0, 1'b1);
    check("mr_busy_before", {63'd0, busy}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", {60'd0, out_valid}, 64'd0);
    check("mr_busy", {63'd0, busy}, 64'd0);
    check("mr_out_data_or", {63'd0, |out_data}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("mr_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(2'd3, 1'b1, 32'hE1, 1'b1);
    check("mr_new_packet_p3", {60'd0, out_valid}, 64'h8);

    // randomized traffic
    in_valid = 1'b0;
    repeat (8000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) remaining--;
      if (acc || !in_valid) begin
        if ($urandom_range(3) != 0) begin
          if (remaining == 0) remaining = $urandom_range(5, 1);
          select   = 2'($urandom);
          in_data  = $urandom;
          in_last  = (remaining == 1);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 4'($urandom) | 4'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    repeat (6) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++)
      check($sformatf("loss_p%0d", p), 64'(exp_q[p].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
